// File: rtl/gf_pkg.sv
// Shared GF(2^M) definitions for the RS decoder blocks: primitive
// polynomials per symbol width, the sequencer state encoding and a
// software-style multiply-by-alpha helper.
package gf_pkg;

  // Primitive polynomials, including the x^M term.
  localparam logic [8:0] GF_POLY_M3 = 9'h00B;
  localparam logic [8:0] GF_POLY_M4 = 9'h013;
  localparam logic [8:0] GF_POLY_M5 = 9'h025;
  localparam logic [8:0] GF_POLY_M6 = 9'h043;
  localparam logic [8:0] GF_POLY_M7 = 9'h089;
  localparam logic [8:0] GF_POLY_M8 = 9'h11D;

  // Sequencer states shared by the search-style engines.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } gf_state_e;

  // Multiply x by alpha in GF(2^m): shift left, reduce by poly when the
  // outgoing MSB was set. Bits at or above m are returned as zero.
  function automatic logic [7:0] gf_xtime(input int m, input logic [8:0] poly,
                                          input logic [7:0] x);
    logic [7:0] r;
    logic       msb;
    msb = x[m-1];
    for (int i = 0; i < 8; i++) begin
      if (i >= m) r[i] = 1'b0;
      else if (i == 0) r[i] = msb & poly[0];
      else r[i] = x[i-1] ^ (msb & poly[i]);
    end
    return r;
  endfunction

endpackage

// File: rtl/gf_xtime_stage.sv
// Combinational multiply-by-alpha for one GF(2^M) element.
module gf_xtime_stage #(
  parameter int         M    = 8,
  parameter logic [8:0] POLY = 9'h11D
) (
  input  logic [M-1:0] x,
  output logic [M-1:0] y
);

  // Each output bit is the shifted-in neighbour, folded with the
  // reduction polynomial whenever the MSB leaves the field.
  for (genvar gi = 0; gi < M; gi++) begin : g_bit
    if (gi == 0) begin : g_lsb
      assign y[gi] = x[M-1] & POLY[gi];
    end else begin : g_upper
      assign y[gi] = x[gi-1] ^ (x[M-1] & POLY[gi]);
    end
  end

endmodule

// File: rtl/gf2idx_seq.sv
// Sequential discrete log for GF(2^M): walks alpha^0, alpha^1, ... until the
// running power equals the latched element, then reports the step count.
// Optional macro GF2IDX_DUAL_STEP_EN tests two powers per cycle, halving
// search latency with identical results.
module gf2idx_seq
  import gf_pkg::*;
#(
  parameter int         M    = 8,
  parameter logic [8:0] POLY = 9'h11D
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] in_elem,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_idx,
  output logic         out_zero,
  output logic         busy
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_SEARCH = SEARCH;
  localparam logic [1:0] S_DONE   = DONE;

  localparam int unsigned N_LAST   = (1 << M) - 2;
  localparam logic [M-1:0] CNT_LAST = N_LAST[M-1:0];
  localparam logic [M-1:0] ONE      = {{(M-1){1'b0}}, 1'b1};

  logic [1:0]   state_reg;
  logic [M-1:0] target_reg;
  logic [M-1:0] cur_reg;
  logic [M-1:0] cnt_reg;
  logic [M-1:0] idx_reg;
  logic         zero_reg;
  logic [M-1:0] cur_x1;

  gf_xtime_stage #(.M(M), .POLY(POLY)) u_step1 (.x(cur_reg), .y(cur_x1));

`ifdef GF2IDX_DUAL_STEP_EN
  localparam int unsigned N_LAST2   = (1 << M) - 3;
  localparam logic [M-1:0] CNT_LAST2 = N_LAST2[M-1:0];
  localparam logic [M-1:0] TWO       = {{(M-2){1'b0}}, 2'b10};

  logic [M-1:0] cur_x2;

  gf_xtime_stage #(.M(M), .POLY(POLY)) u_step2 (.x(cur_x1), .y(cur_x2));
`endif

  assign in_ready  = (state_reg == S_IDLE);
  assign out_valid = (state_reg == S_DONE);
  assign busy      = (state_reg != S_IDLE);
  assign out_idx   = idx_reg;
  assign out_zero  = zero_reg;

  // Accept, search and hand off one element at a time.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      target_reg <= '0;
      cur_reg    <= ONE;
      cnt_reg    <= '0;
      idx_reg    <= '0;
      zero_reg   <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            target_reg <= in_elem;
            cur_reg    <= ONE;
            cnt_reg    <= '0;
            if (in_elem == '0) begin
              state_reg <= S_DONE;
              idx_reg   <= '1;
              zero_reg  <= 1'b1;
            end else begin
              state_reg <= S_SEARCH;
            end
          end
        end
        S_SEARCH: begin
`ifdef GF2IDX_DUAL_STEP_EN
          if (cur_reg == target_reg) begin
            state_reg <= S_DONE;
            idx_reg   <= cnt_reg;
            zero_reg  <= 1'b0;
          end else if (cur_x1 == target_reg) begin
            state_reg <= S_DONE;
            idx_reg   <= cnt_reg + ONE;
            zero_reg  <= 1'b0;
          end else if (cnt_reg >= CNT_LAST2) begin
            // Whole cycle walked without a hit: polynomial is not primitive.
            state_reg <= S_DONE;
            idx_reg   <= '1;
            zero_reg  <= 1'b1;
          end else begin
            cur_reg <= cur_x2;
            cnt_reg <= cnt_reg + TWO;
          end
`else
          if (cur_reg == target_reg) begin
            state_reg <= S_DONE;
            idx_reg   <= cnt_reg;
            zero_reg  <= 1'b0;
          end else if (cnt_reg == CNT_LAST) begin
            // Whole cycle walked without a hit: polynomial is not primitive.
            state_reg <= S_DONE;
            idx_reg   <= '1;
            zero_reg  <= 1'b1;
          end else begin
            cur_reg <= cur_x1;
            cnt_reg <= cnt_reg + ONE;
          end
`endif
        end
        S_DONE: begin
          if (out_ready) state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gf2idx_seq.sv
// Directed bench for gf2idx_seq: M=8 (POLY 0x11D) and M=3 (POLY 0xB).
module tb_gf2idx_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       iv8, ir8, ov8, or8, oz8, bz8;
  logic [7:0] ie8, oi8;
  logic       iv3, ir3, ov3, or3, oz3, bz3;
  logic [2:0] ie3, oi3;

  int n_cmp = 0;
  int n_bad = 0;

  int log8[256];
  int log3[8];

  gf2idx_seq #(.M(8), .POLY(9'h11D)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_elem(ie8),
    .out_valid(ov8), .out_ready(or8), .out_idx(oi8), .out_zero(oz8), .busy(bz8)
  );

  gf2idx_seq #(.M(3), .POLY(9'h00B)) dut3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .in_elem(ie3),
    .out_valid(ov3), .out_ready(or3), .out_idx(oi3), .out_zero(oz3), .busy(bz3)
  );

  // Expected accept-to-valid latency for a nonzero element with log k.
  function automatic int exp_lat(input int k);
`ifdef GF2IDX_DUAL_STEP_EN
    return k / 2 + 2;
`else
    return k + 2;
`endif
  endfunction

  // Independent antilog walk to build reference log tables.
  task automatic build_tables();
    int v;
    v = 1;
    for (int i = 0; i < 255; i++) begin
      log8[v] = i;
      v = v << 1;
      if ((v & 256) != 0) v = v ^ 32'h11D;
    end
    v = 1;
    for (int i = 0; i < 7; i++) begin
      log3[v] = i;
      v = v << 1;
      if ((v & 8) != 0) v = v ^ 32'h00B;
    end
  endtask

  task automatic run8(input logic [7:0] e, output logic [7:0] idx,
                      output logic z, output int lat);
    iv8 = 1'b1; ie8 = e;
    @(posedge clk); #1;
    iv8 = 1'b0; ie8 = ~e;
    lat = 1;
    while (ov8 !== 1'b1 && lat < 600) begin
      @(posedge clk); #1; lat++;
    end
    idx = oi8; z = oz8;
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
    $display("m8 elem=%0d idx=%0d zero=%0d lat=%0d", e, idx, z, lat);
  endtask

  task automatic run3(input logic [2:0] e, output logic [2:0] idx,
                      output logic z, output int lat);
    iv3 = 1'b1; ie3 = e;
    @(posedge clk); #1;
    iv3 = 1'b0; ie3 = ~e;
    lat = 1;
    while (ov3 !== 1'b1 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    idx = oi3; z = oz3;
    or3 = 1'b1;
    @(posedge clk); #1;
    or3 = 1'b0;
    $display("m3 elem=%0d idx=%0d zero=%0d lat=%0d", e, idx, z, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    iv8 = 1'b0; ie8 = '0; or8 = 1'b0;
    iv3 = 1'b0; ie3 = '0; or3 = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    n_cmp++;
    if ({ir8, ov8, oi8, oz8, bz8} !== {1'b1, 1'b0, 8'd0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset8 got ready=%b valid=%b idx=%0d zero=%b busy=%b want 1 0 0 0 0",
               ir8, ov8, oi8, oz8, bz8);
    end
    n_cmp++;
    if ({ir3, ov3, oi3, oz3, bz3} !== {1'b1, 1'b0, 3'd0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset3 got ready=%b valid=%b idx=%0d zero=%b busy=%b want 1 0 0 0 0",
               ir3, ov3, oi3, oz3, bz3);
    end
  endtask

  task automatic test_directed();
    logic [7:0] elems[4] = '{8'd1, 8'd29, 8'd142, 8'd0};
    logic [7:0] idxs[4]  = '{8'd0, 8'd8, 8'd254, 8'd255};
    logic       zs[4]    = '{1'b0, 1'b0, 1'b0, 1'b1};
    int         lats[4];
    logic [7:0] idx;
    logic       z;
    int         lat;
    lats = '{exp_lat(0), exp_lat(8), exp_lat(254), 1};
    for (int i = 0; i < 4; i++) begin
      run8(elems[i], idx, z, lat);
      n_cmp++;
      if (idx !== idxs[i] || z !== zs[i]) begin
        n_bad++;
        $display("FAIL directed elem=%0d got idx=%0d zero=%b want idx=%0d zero=%b",
                 elems[i], idx, z, idxs[i], zs[i]);
      end
      n_cmp++;
      if (lat != lats[i]) begin
        n_bad++;
        $display("FAIL latency elem=%0d got %0d want %0d", elems[i], lat, lats[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int waitc;
    iv8 = 1'b1; ie8 = 8'd29;
    @(posedge clk); #1;
    iv8 = 1'b0;
    waitc = 0;
    while (ov8 !== 1'b1 && waitc < 600) begin
      @(posedge clk); #1; waitc++;
    end
    for (int c = 0; c < 5; c++) begin
      iv8 = 1'b1; ie8 = 8'd5;
      n_cmp++;
      if ({ov8, oi8, oz8, ir8} !== {1'b1, 8'd8, 1'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL stall cyc=%0d got valid=%b idx=%0d zero=%b ready=%b want 1 8 0 0",
                 c, ov8, oi8, oz8, ir8);
      end
      @(posedge clk); #1;
    end
    iv8 = 1'b0;
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
    $display("m8 elem=29 stalled 5 cycles then released");
    n_cmp++;
    if ({ov8, ir8, bz8} !== {1'b0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL release got valid=%b ready=%b busy=%b want 0 1 0", ov8, ir8, bz8);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bz8 !== 1'b0) begin
      n_bad++;
      $display("FAIL stray_accept got busy=%b want 0", bz8);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] idx;
    logic       z;
    int         lat;
    iv8 = 1'b1; ie8 = 8'd142;
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (20) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    $display("m8 elem=142 aborted by reset");
    n_cmp++;
    if ({ir8, ov8, bz8, oi8, oz8} !== {1'b1, 1'b0, 1'b0, 8'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL midreset got ready=%b valid=%b busy=%b idx=%0d zero=%b want 1 0 0 0 0",
               ir8, ov8, bz8, oi8, oz8);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({ov8, bz8} !== 2'b00) begin
      n_bad++;
      $display("FAIL midreset_quiet got valid=%b busy=%b want 0 0", ov8, bz8);
    end
    run8(8'd2, idx, z, lat);
    n_cmp++;
    if (idx !== 8'd1 || z !== 1'b0 || lat != exp_lat(1)) begin
      n_bad++;
      $display("FAIL after_reset elem=2 got idx=%0d zero=%b lat=%0d want 1 0 %0d",
               idx, z, lat, exp_lat(1));
    end
  endtask

  task automatic test_sweep8();
    logic [7:0] idx;
    logic       z;
    int         lat;
    for (int e = 1; e < 256; e++) begin
      run8(8'(e), idx, z, lat);
      n_cmp++;
      if (idx !== 8'(log8[e]) || z !== 1'b0 || lat != exp_lat(log8[e])) begin
        n_bad++;
        $display("FAIL sweep8 elem=%0d got idx=%0d zero=%b lat=%0d want %0d 0 %0d",
                 e, idx, z, lat, log8[e], exp_lat(log8[e]));
      end
    end
  endtask

  task automatic test_sweep3();
    logic [2:0] idx;
    logic       z;
    int         lat;
    for (int e = 1; e < 8; e++) begin
      run3(3'(e), idx, z, lat);
      n_cmp++;
      if (idx !== 3'(log3[e]) || z !== 1'b0 || lat != exp_lat(log3[e])) begin
        n_bad++;
        $display("FAIL sweep3 elem=%0d got idx=%0d zero=%b lat=%0d want %0d 0 %0d",
                 e, idx, z, lat, log3[e], exp_lat(log3[e]));
      end
    end
    run3(3'd5, idx, z, lat);
    n_cmp++;
    if (idx !== 3'd6 || z !== 1'b0) begin
      n_bad++;
      $display("FAIL m3_elem5 got idx=%0d zero=%b want 6 0", idx, z);
    end
    run3(3'd3, idx, z, lat);
    n_cmp++;
    if (idx !== 3'd3 || z !== 1'b0) begin
      n_bad++;
      $display("FAIL m3_elem3 got idx=%0d zero=%b want 3 0", idx, z);
    end
    run3(3'd0, idx, z, lat);
    n_cmp++;
    if (idx !== 3'd7 || z !== 1'b1 || lat != 1) begin
      n_bad++;
      $display("FAIL m3_zero got idx=%0d zero=%b lat=%0d want 7 1 1", idx, z, lat);
    end
  endtask

  initial begin
    build_tables();
    test_reset();
    test_directed();
    test_backpressure();
    test_mid_reset();
    test_sweep8();
    test_sweep3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
